// File: rtl/serial_alu_ctrl.sv
// Bit-serial ALU sequencer: drives one external 1-bit slice LSB-first over WIDTH cycles.
// Optional SERIAL_ALU_PERF_EN adds a saturating 16-bit completed-operation counter.
module serial_alu_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] src1_i,
    input  logic [WIDTH-1:0] src2_i,
    input  logic [3:0]       ctrl_i,
    output logic             ready_o,
    output logic             done_o,
    output logic [WIDTH-1:0] result_o,
    output logic             zero_o,
    output logic             overflow_o,
    output logic             slice_a_o,
    output logic             slice_b_o,
    output logic [3:0]       slice_op_o,
    output logic             slice_cin_o,
    input  logic             slice_result_i,
    input  logic             slice_cout_i
`ifdef SERIAL_ALU_PERF_EN
    ,
    output logic [15:0]      perf_ops_o
`endif
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       op_q, op_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d, ovf_q, ovf_d;

    logic [WIDTH-1:0] final_word;
    logic             ovf_bit;

    // The last slice bit has not yet entered the shift register on the final edge.
    assign final_word = {slice_result_i, sh_q[WIDTH-1:1]};
    assign ovf_bit    = carry_q ^ slice_cout_i;

    assign result_o   = result_q;
    assign zero_o     = zero_q;
    assign overflow_o = ovf_q;
    assign slice_op_o = op_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            sh_q     <= '0;
            result_q <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sh_q     <= sh_d;
            result_q <= result_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    always_comb begin
        logic [WIDTH-1:0] word;
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        sh_d        = sh_q;
        result_d    = result_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        carry_d     = carry_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        ready_o     = 1'b0;
        done_o      = 1'b0;
        slice_a_o   = 1'b0;
        slice_b_o   = 1'b0;
        slice_cin_o = 1'b0;
        word        = '0;

        case (state_q)
            IDLE, DONE: begin
                ready_o = 1'b1;
                done_o  = (state_q == DONE);
                state_d = IDLE;
                if (start_i) begin
                    a_d     = src1_i;
                    b_d     = src2_i;
                    op_d    = ctrl_i;
                    cnt_d   = '0;
                    carry_d = (ctrl_i == OP_SUB) || (ctrl_i == OP_SLT);
                    state_d = RUN;
                end
            end
            RUN: begin
                slice_a_o   = a_q[0];
                slice_b_o   = b_q[0];
                slice_cin_o = carry_q;
                a_d         = a_q >> 1;
                b_d         = b_q >> 1;
                sh_d        = final_word;
                carry_d     = slice_cout_i;
                cnt_d       = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                    ovf_d   = 1'b0;
                    case (op_q)
                        OP_ADD, OP_SUB: begin
                            word  = final_word;
                            ovf_d = ovf_bit;
                        end
                        // Sign of the difference, corrected when the subtraction overflowed.
                        OP_SLT:        word = {{(WIDTH-1){1'b0}}, slice_result_i ^ ovf_bit};
                        OP_AND, OP_OR: word = final_word;
                        default:       word = '0;
                    endcase
                    result_d = word;
                    zero_d   = (word == '0);
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef SERIAL_ALU_PERF_EN
    logic [15:0] perf_q;
    assign perf_ops_o = perf_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_q <= '0;
        end else if (state_q == DONE && perf_q != 16'hFFFF) begin
            perf_q <= perf_q + 16'd1;
        end
    end
`endif

endmodule
